warp_fetch_scheduler: RTL
=========================

// Module: warp_fetch_scheduler
// PURPOSE
//  Per-warp PC bank and round-robin fetch arbiter that feeds the I-cache.
//  Each cycle it picks one eligible warp and issues that warp's PC, then advances the PC.
//  It consumes the SIMT stack's redirect outputs (Qual1/Qual2 + per-warp target address)
//  and the SIMT stall mask, so it sits directly downstream of SIMT at the Fetch stage.
//  Warps are started by the task manager and retired on EXIT from decode.
// PARAMETERS
//  NUM_WARPS  8   number of warps; warp-ID width = log2(NUM_WARPS) = 3
//  PC_WIDTH   10  PC / target-address width in bits
//  PC_INC     4   PC increment per fetched instruction (byte address)
// PORTS
//  clk                  in   1     clock, all state updates on rising edge
//  rst                  in   1     synchronous, active-low reset
//  Start_TM_IF          in   1     task manager starts a warp this cycle
//  WarpID_TM_IF         in   3     warp being started
//  StartPC_TM_IF        in   10    initial PC of the started warp
//  Exit_ID_IF           in   8     one-hot, warp decoded EXIT -> deactivate
//  UpdatePC_Qual1_SIMT_IF in 8     per-warp redirect request (stack pop/branch)
//  UpdatePC_Qual2_SIMT_IF in 8     per-warp redirect request (call/jump/ret)
//  Stall_SIMT_IF        in   8     per-warp fetch stall from SIMT
//  TA_SIMT_IF           in   80    packed targets; warp w at [10w+9:10w]
//  IBFull_IB_IF         in   8     per-warp IBuffer full
//  Stall_IC_IF          in   1     I-cache cannot accept (miss), global freeze
//  Valid_IF_IC          out  1     fetch request valid (registered)
//  PC_IF_IC             out  10    fetch PC (registered)
//  WarpID_IF_IC         out  3     fetch warp ID (registered)
//  Active_IF_TM         out  8     per-warp active mask
// BEHAVIOUR
//  Reset (rst==0 at edge): all PC=0, Active=0, RR pointer=7 (so warp0 is first),
//  Valid_IF_IC=0, PC_IF_IC=0, WarpID_IF_IC=0. Reset overrides every other input.
//  Per-warp next-PC priority, highest first:
//  1. Start_TM_IF for warp w: PC=StartPC, Active=1.
//  2. Exit_ID_IF[w]: Active=0; PC unchanged.
//  3. Qual1[w] | Qual2[w]: PC = TA slice w.
//  4. w fetched this cycle: PC = PC + PC_INC, modulo 2^10 (1020 -> 0).
//  Start and Exit on the same warp in the same cycle: warp ends Active=1.
//  Eligible[w] = Active[w] & ~Stall_SIMT_IF[w] & ~IBFull_IB_IF[w]
//                & ~Qual1[w] & ~Qual2[w] & ~Exit[w] & ~(Start & WarpID_TM==w).
//  A warp being redirected, started or exited is never fetched in that cycle.
//  Arbiter: round-robin. Search begins at RR+1 mod 8 and takes the first eligible warp.
//  On a grant, RR <= granted ID. With no eligible warp, RR is held.
//  Output register, 1-cycle latency from the decision:
//  - grant: Valid=1, PC=pre-increment PC, WarpID=grant.
//  - no grant: Valid=0; PC and WarpID hold their old values.
//  Stall_IC_IF=1: no grant and no fetch increment. Valid, PC, WarpID and RR all hold.
//  Starts, exits and redirects still update the PC bank during Stall_IC_IF.
//  Redirect of a warp whose stale fetch is already in the output register: not
//  cancelled here. SIMT DropInstr removes the stale instruction downstream.
//  Active_IF_TM is the registered Active vector.
// TESTING
//  T1 Reset, Start w0 PC=0x010, nothing else -> Valid=1 on consecutive cycles,
//     PC 0x010,0x014,0x018, WarpID 0.
//  T2 Start w1 @0x100 and w3 @0x200 -> grants alternate 1,3,1,3;
//     PCs 0x100,0x200,0x104,0x204.
//  T3 w1 running, Qual1[1]=1 with TA1=0x050 -> no w1 grant that cycle;
//     next w1 fetch PC=0x050, then 0x054.
//  T4 Stall_IC_IF=1 for 3 cycles -> outputs frozen, PCs unchanged;
//     when released, fetch continues from the next warp in round-robin order.
//  T5 w2 at PC=0x3FC -> fetch 0x3FC, then 0x000 (wrap);
//     IBFull[2]=1 -> w2 skipped, Valid=0 if it is the only warp.
//  T6 Drive rst=0 mid-stream with Start asserted -> next cycle Valid=0,
//     Active=0, all PCs 0; Start is ignored.

Source files
------------

// File: rtl/warp_fetch_scheduler.sv
// -----------------------------------------------------------------------------
// warp_fetch_scheduler
//   Per-warp PC bank plus a round-robin fetch arbiter feeding the I-cache.
//   Each cycle one eligible warp is granted, its PC is issued through a
//   registered output stage and the warp's PC advances by PC_INC.
//   Redirects from the SIMT stack, starts from the task manager and EXITs
//   from decode update the PC bank / active mask with fixed priority.
//
// Ports
//   clk                      clock, rising edge
//   rst                      synchronous, active-low reset
//   Start_TM_IF              start a warp this cycle
//   WarpID_TM_IF             warp being started
//   StartPC_TM_IF            initial PC of the started warp
//   Exit_ID_IF               one-hot EXIT, deactivates the warp
//   UpdatePC_Qual1_SIMT_IF   per-warp redirect (stack pop / branch)
//   UpdatePC_Qual2_SIMT_IF   per-warp redirect (call / jump / ret)
//   Stall_SIMT_IF            per-warp fetch stall
//   TA_SIMT_IF               packed redirect targets, warp w at [PC_WIDTH*w +: PC_WIDTH]
//   IBFull_IB_IF             per-warp instruction buffer full
//   Stall_IC_IF              I-cache busy, freezes the fetch pipeline
//   Valid_IF_IC              fetch request valid (registered)
//   PC_IF_IC                 fetch PC (registered)
//   WarpID_IF_IC             fetch warp ID (registered)
//   Active_IF_TM             registered active mask
// -----------------------------------------------------------------------------
module warp_fetch_scheduler #(
  parameter int unsigned NUM_WARPS = 8,
  parameter int unsigned PC_WIDTH  = 10,
  parameter int unsigned PC_INC    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          Start_TM_IF,
  input  logic [$clog2(NUM_WARPS)-1:0]  WarpID_TM_IF,
  input  logic [PC_WIDTH-1:0]           StartPC_TM_IF,
  input  logic [NUM_WARPS-1:0]          Exit_ID_IF,
  input  logic [NUM_WARPS-1:0]          UpdatePC_Qual1_SIMT_IF,
  input  logic [NUM_WARPS-1:0]          UpdatePC_Qual2_SIMT_IF,
  input  logic [NUM_WARPS-1:0]          Stall_SIMT_IF,
  input  logic [NUM_WARPS*PC_WIDTH-1:0] TA_SIMT_IF,
  input  logic [NUM_WARPS-1:0]          IBFull_IB_IF,
  input  logic                          Stall_IC_IF,
  output logic                          Valid_IF_IC,
  output logic [PC_WIDTH-1:0]           PC_IF_IC,
  output logic [$clog2(NUM_WARPS)-1:0]  WarpID_IF_IC,
  output logic [NUM_WARPS-1:0]          Active_IF_TM
);

  localparam int unsigned WidW = $clog2(NUM_WARPS);

  // State
  logic [PC_WIDTH-1:0]  r_pc [NUM_WARPS];
  logic [NUM_WARPS-1:0] r_active;
  logic [WidW-1:0]      r_rr;
  logic                 r_valid;
  logic [PC_WIDTH-1:0]  r_pc_out;
  logic [WidW-1:0]      r_wid_out;

  // Combinational
  logic [NUM_WARPS-1:0] w_start_oh;
  logic [NUM_WARPS-1:0] w_redirect;
  logic [NUM_WARPS-1:0] w_eligible;
  logic                 w_grant_vld;
  logic [WidW-1:0]      w_grant_id;
  logic [NUM_WARPS-1:0] w_grant_oh;
  logic [PC_WIDTH-1:0]  w_pc_nxt [NUM_WARPS];
  logic [NUM_WARPS-1:0] w_active_nxt;

  always_comb begin
    w_start_oh = '0;
    if (Start_TM_IF) w_start_oh[WarpID_TM_IF] = 1'b1;
  end

  assign w_redirect = UpdatePC_Qual1_SIMT_IF | UpdatePC_Qual2_SIMT_IF;

  // A warp that is being started, exited or redirected is never fetched this cycle.
  assign w_eligible = r_active & ~Stall_SIMT_IF & ~IBFull_IB_IF & ~w_redirect
                    & ~Exit_ID_IF & ~w_start_oh;

  // Round-robin: scan from r_rr+1 around to r_rr, take the first eligible warp.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    for (int unsigned i = 1; i <= NUM_WARPS; i++) begin
      idx = (32'(r_rr) + i) % NUM_WARPS;
      if (!w_grant_vld && w_eligible[idx]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = WidW'(idx);
      end
    end
    // I-cache freeze suppresses the grant, which also blocks the PC increment.
    if (Stall_IC_IF) w_grant_vld = 1'b0;
  end

  always_comb begin
    w_grant_oh = '0;
    if (w_grant_vld) w_grant_oh[w_grant_id] = 1'b1;
  end

  // Per-warp next PC: start > exit (hold) > redirect > fetch increment.
  always_comb begin
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      w_pc_nxt[w] = r_pc[w];
      if (w_start_oh[w]) begin
        w_pc_nxt[w] = StartPC_TM_IF;
      end else if (Exit_ID_IF[w]) begin
        w_pc_nxt[w] = r_pc[w];
      end else if (w_redirect[w]) begin
        w_pc_nxt[w] = TA_SIMT_IF[w*PC_WIDTH +: PC_WIDTH];
      end else if (w_grant_oh[w]) begin
        w_pc_nxt[w] = r_pc[w] + PC_WIDTH'(PC_INC);
      end
    end
  end

  // Start wins over a same-cycle exit on the same warp.
  assign w_active_nxt = (r_active & ~Exit_ID_IF) | w_start_oh;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) r_pc[w] <= '0;
      r_active  <= '0;
      r_rr      <= WidW'(NUM_WARPS - 1);
      r_valid   <= 1'b0;
      r_pc_out  <= '0;
      r_wid_out <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) r_pc[w] <= w_pc_nxt[w];
      r_active <= w_active_nxt;
      if (w_grant_vld) begin
        r_valid   <= 1'b1;
        r_pc_out  <= r_pc[w_grant_id];
        r_wid_out <= w_grant_id;
        r_rr      <= w_grant_id;
      end else if (!Stall_IC_IF) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign Valid_IF_IC  = r_valid;
  assign PC_IF_IC     = r_pc_out;
  assign WarpID_IF_IC = r_wid_out;
  assign Active_IF_TM = r_active;

endmodule
